// File: rtl/fire6_pkg.sv
//------------------------------------------------------------------------------
// fire6_pkg : constants and state encoding shared by the fire6 expand blocks.
//------------------------------------------------------------------------------
`default_nettype none

package fire6_pkg;

    localparam int F6_WIDTH = 16;
    localparam int F6_W_IN  = 16;
    localparam int F6_H_IN  = 16;
    localparam int F6_CHIN  = 64;
    localparam int F6_GAP   = 1;
    localparam int F6_NWIN  = F6_W_IN * F6_H_IN;
    localparam int F6_DEPTH = F6_NWIN * F6_CHIN;
    localparam int F6_AW    = $clog2(F6_DEPTH);
    localparam int F6_WINW  = $clog2(F6_NWIN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    // Counter width that stays legal when the counted range is a single value.
    function automatic int f6_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fmap_ram_1r1w.sv
//------------------------------------------------------------------------------
// fmap_ram_1r1w : single-clock feature-map buffer, one write port and one
// registered read port (read data updates only when rd_en_i is high).
//------------------------------------------------------------------------------
`default_nettype none

module fmap_ram_1r1w #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16384,
    parameter int AW    = 14
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/fire6_ifm_streamer.sv
//------------------------------------------------------------------------------
// fire6_ifm_streamer : buffers the squeeze map and streams it channel-major per
// window with GAP idle beats per window for the expand MAC clear/sample slot.
//------------------------------------------------------------------------------
`default_nettype none

module fire6_ifm_streamer
    import fire6_pkg::*;
#(
    parameter int WIDTH = F6_WIDTH,
    parameter int W_IN  = F6_W_IN,
    parameter int H_IN  = F6_H_IN,
    parameter int CHIN  = F6_CHIN,
    parameter int GAP   = F6_GAP,
    parameter int DEPTH = W_IN * H_IN * CHIN
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en_i,
    input  logic [$clog2(DEPTH)-1:0]     wr_addr_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    input  logic                         start_i,
    input  logic                         ready_i,
    output logic [WIDTH-1:0]             ifm_o,
    output logic                         ifm_valid_o,
    output logic                         ifm_first_o,
    output logic                         ifm_last_o,
    output logic [$clog2(W_IN*H_IN)-1:0] win_idx_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         wr_err_o
);

    localparam int NWIN = W_IN * H_IN;
    localparam int AW   = $clog2(DEPTH);
    localparam int WW   = $clog2(NWIN);
    localparam int CW   = f6_bits(CHIN);
    localparam int GW   = f6_bits(GAP);

    state_e          state_q;
    logic [CW-1:0]   ch_q;
    logic [WW-1:0]   win_q;
    logic [GW-1:0]   gap_q;
    logic            busy_q;
    logic            wr_err_q;

    logic            p_valid_q, p_first_q, p_last_q, p_done_q;
    logic [WW-1:0]   p_win_q;
    logic [WIDTH-1:0] ifm_q;
    logic            ifm_valid_q, ifm_first_q, ifm_last_q, done_q;
    logic [WW-1:0]   win_idx_q;

    logic            w_streaming;
    logic            w_adv;
    logic            w_rd_en;
    logic [AW-1:0]   w_rd_addr;
    logic [WIDTH-1:0] w_rd_data;

    // Only the streaming states honour back-pressure; IDLE and FIN always move.
    assign w_streaming = (state_q == ST_RD) || (state_q == ST_GAP);
    assign w_adv       = !(w_streaming && !ready_i);
    assign w_rd_en     = (state_q == ST_RD) && ready_i;
    assign w_rd_addr   = AW'(win_q) * AW'(CHIN) + AW'(ch_q);

    fmap_ram_1r1w #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en_i && !busy_q),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_en_i   (w_rd_en),
        .rd_addr_i (w_rd_addr),
        .rd_data_o (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ch_q     <= '0;
            win_q    <= '0;
            gap_q    <= '0;
            busy_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            if (wr_en_i && busy_q) begin
                wr_err_q <= 1'b1;
            end
            // busy drops on the same edge that presents the done pulse.
            if (p_done_q) begin
                busy_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_i && !busy_q) begin
                        state_q <= ST_RD;
                        ch_q    <= '0;
                        win_q   <= '0;
                        gap_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RD: begin
                    if (ready_i) begin
                        if (ch_q == CW'(CHIN - 1)) begin
                            state_q <= ST_GAP;
                            gap_q   <= '0;
                        end else begin
                            ch_q <= ch_q + CW'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (ready_i) begin
                        if (gap_q == GW'(GAP - 1)) begin
                            if (win_q == WW'(NWIN - 1)) begin
                                state_q <= ST_FIN;
                            end else begin
                                win_q   <= win_q + WW'(1);
                                ch_q    <= '0;
                                state_q <= ST_RD;
                            end
                        end else begin
                            gap_q <= gap_q + GW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Two-stage sideband: issue stage aligns with RAM read data, then outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid_q   <= 1'b0;
            p_first_q   <= 1'b0;
            p_last_q    <= 1'b0;
            p_done_q    <= 1'b0;
            p_win_q     <= '0;
            ifm_q       <= '0;
            ifm_valid_q <= 1'b0;
            ifm_first_q <= 1'b0;
            ifm_last_q  <= 1'b0;
            done_q      <= 1'b0;
            win_idx_q   <= '0;
        end else if (w_adv) begin
            p_valid_q   <= (state_q == ST_RD);
            p_first_q   <= (state_q == ST_RD) && (ch_q == '0);
            p_last_q    <= (state_q == ST_RD) && (ch_q == CW'(CHIN - 1));
            p_done_q    <= (state_q == ST_FIN);
            p_win_q     <= win_q;
            ifm_q       <= p_valid_q ? w_rd_data : '0;
            ifm_valid_q <= p_valid_q;
            ifm_first_q <= p_first_q;
            ifm_last_q  <= p_last_q;
            done_q      <= p_done_q;
            win_idx_q   <= p_win_q;
        end
    end

    assign ifm_o       = ifm_q;
    assign ifm_valid_o = ifm_valid_q;
    assign ifm_first_o = ifm_first_q;
    assign ifm_last_o  = ifm_last_q;
    assign win_idx_o   = win_idx_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign wr_err_o    = wr_err_q;

endmodule

`default_nettype wire

// File: doc/fire6_ifm_streamer.md
Name: fire6_ifm_streamer

Overview:
Producer end of the fire6 expand 1x1 ifm interface. It buffers the 16x16x64 squeeze output in internal RAM. On start, it streams the buffer one 16-bit value per cycle, channel-major within each spatial window: CHIN channel values, then GAP idle cycles. This matches the expand layer's CHIN+1-cycle MAC clear/sample period. It sits between the fire6 squeeze writer and the fire6 expand 1x1/3x3 consumers.

Parameters:
WIDTH, 16, data width of ifm and write data
W_IN, 16, feature-map width
H_IN, 16, feature-map height
CHIN, 64, channels per spatial window
GAP, 1, idle cycles after each window (consumer clr/sample slot)
DEPTH, W_IN*H_IN*CHIN, buffer words (derived)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
wr_en  in  1  squeeze-side write strobe
wr_addr  in  $clog2(DEPTH)  write address = pix*CHIN + ch
wr_data  in  WIDTH  feature value
start  in  1  begin streaming the whole map
ready  in  1  consumer may accept; low stalls the stream
ifm  out  WIDTH  streamed value
ifm_valid  out  1  ifm carries a channel value
ifm_first  out  1  qualifies the ch==0 beat of a window
ifm_last  out  1  qualifies the ch==CHIN-1 beat of a window
win_idx  out  $clog2(W_IN*H_IN)  window index of the current beat
busy  out  1  streaming in progress
done  out  1  one-cycle pulse after the final window's gap
wr_err  out  1  sticky: a write arrived while busy

Behaviour:
- Reset (rst low, async): state IDLE. All counters are 0. ifm=0; ifm_valid, ifm_first, ifm_last, busy, done and wr_err are all 0; win_idx=0. RAM contents are not reset.
- Writes: when wr_en=1 and busy=0, mem[wr_addr]<=wr_data. When wr_en=1 and busy=1, the write is dropped and wr_err<=1. wr_err clears only on reset.
- RAM is single-clock with a registered read and 1-cycle read latency. rd_addr = win*CHIN + ch.
- FSM states: IDLE, RD, GAP, FIN.
  - IDLE -> RD on start=1. Counters load win=0, ch=0, and busy<=1 in the same edge.
  - RD: each cycle with ready=1, issue a read at (win,ch) and increment ch. When ch==CHIN-1 is issued, go to GAP with gap counter 0.
  - GAP: counts GAP cycles (ready-gated). Then, if win==W_IN*H_IN-1, go to FIN; otherwise win++, ch=0, go to RD.
  - FIN: done=1 for one cycle, busy<=0, go to IDLE.
- Output pipeline: the output register tracks RAM read data. ifm_valid, ifm_first, ifm_last and win_idx are delayed one cycle with the read.
  - First ifm_valid=1 occurs 2 cycles after the edge that sampled start=1.
  - During GAP beats, ifm_valid=0 and ifm=0.
  - Unstalled window period is exactly CHIN+GAP cycles. The full map takes W_IN*H_IN*(CHIN+GAP) cycles, plus 2 cycles of latency, plus 1 cycle for FIN.
- Stall: while ready=0, the FSM, counters, RAM read enable and output registers all hold. The outputs keep their current values, including ifm_valid. This gives no loss and no duplication. ready is not examined in IDLE or FIN.
- start while busy=1 is ignored. start in the FIN cycle is ignored.
- If start and wr_en are asserted in the same cycle from IDLE, the write completes (busy is still 0). Its data is visible to the stream if its address has not yet been read.
- Reset mid-stream aborts immediately to the reset values. Buffer contents are retained, so a fresh start re-streams from window 0.
- win_idx wraps only through reset or a new start. There is no modulo wrap inside a run.

Decomposition:
- Shared package fire6_pkg: WIDTH, W_IN, H_IN, CHIN, derived DEPTH and address widths, and the state enum {IDLE,RD,GAP,FIN}. fire6_expand_1 and the 3x3 expand block use the same constants.
- One sub-module: fmap_ram_1r1w, a single-clock registered-read RAM (wr_en/wr_addr/wr_data, rd_en/rd_addr/rd_data) with rd_en held low during stall.

Test Plan:
- Fill pattern mem[a]=a[15:0]. Start with ready=1 and W_IN=H_IN=2, CHIN=4, GAP=1 -> ifm sequence 0,1,2,3,gap,4,5,6,7,gap,...,15. ifm_first on values 0,4,8,12; ifm_last on 3,7,11,15. done exactly 2+4*5+1=23 cycles after start; busy low afterwards.
- Default parameters, ready=1 -> period between consecutive ifm_first pulses is 65 cycles. 256 windows. done at cycle 2+256*65+1 after start.
- Drop ready for 3 cycles mid-window at ch=10 -> ifm holds value 10 with valid=1 for the stall. Next beat is 11. No value is skipped or repeated, and total time grows by exactly 3 cycles.
- Write to address 5 while busy -> wr_err=1 and stays 1. mem[5] keeps its old value on the next run. A second start while busy has no effect on the sequence.
- Assert rst low during window 3 -> all outputs read 0 within the same cycle (async). Restart -> stream resumes from window 0 with the original data.
- Same-cycle start+write to address 0 from IDLE -> the first streamed value equals the new write data.
